// File: rtl/mem_io_responder_pkg.sv
// Shared bus encodings, responder FSM states and address-decode targets.
// Imported by the memory/IO responder and its RAM.
package mem_io_responder_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MILL   = 2'b11
  } mem_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_LED,
    TGT_SW,
    TGT_ERR
  } target_t;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;
  localparam int         WAIT_W       = 3;

endpackage

// File: rtl/mem_io_responder_ram_sp.sv
// Single-port synchronous RAM with registered read.
// The read register updates only when re is high, so a loaded word stays put.
module ram_sp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Bus target for the CPU: decodes each command to RAM, the LED register or the
// switch port, and answers with a one-cycle ack. Also holds the sticky halt flag.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int               ADDR_W    = 9,
  parameter int               DATA_W    = 16,
  parameter int               RAM_DEPTH = 256,
  parameter int               RAM_WAIT  = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(LED_ADDR_DEF),
  parameter logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(SW_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ack,
  output logic              bus_err,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out,
  input  logic              halt_in,
  output logic              halt_led
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  function automatic target_t decode(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr);
    if (cmd == MILL) return TGT_ERR;
    if ({1'b0, addr} < (ADDR_W+1)'(RAM_DEPTH)) return TGT_RAM;
    if (addr == LED_ADDR) return TGT_LED;
    if (addr == SW_ADDR) return (cmd == MWRITE) ? TGT_ERR : TGT_SW;
    return TGT_ERR;
  endfunction

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] cnt_reg, cnt_next;
  mem_cmd_t          cmd_reg;
  target_t           tgt_reg;
  logic [RAM_AW-1:0] ram_addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] rd_reg;
  logic              src_ram_reg;
  logic [7:0]        led_reg;
  logic [7:0]        sw_meta_reg, sw_sync_reg;
  logic              halt_reg;

  logic              in_idle;
  logic              enter_ack;
  mem_cmd_t          cur_cmd;
  target_t           cur_tgt;
  logic [RAM_AW-1:0] cur_ram_addr;
  logic [DATA_W-1:0] cur_data;
  logic [DATA_W-1:0] ram_q;
  logic              ram_we, ram_re;

  // In IDLE the live bus is used so zero-wait accesses complete on the sampling edge;
  // afterwards only the latched copies matter.
  assign in_idle      = (state_reg == ST_IDLE);
  assign cur_cmd      = in_idle ? mem_cmd_t'(mem_cmd) : cmd_reg;
  assign cur_tgt      = in_idle ? decode(mem_cmd, mem_addr) : tgt_reg;
  assign cur_ram_addr = in_idle ? mem_addr[RAM_AW-1:0] : ram_addr_reg;
  assign cur_data     = in_idle ? write_data : data_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_ack  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_cmd != MNONE) begin
          if (cur_tgt == TGT_RAM && RAM_WAIT > 0) begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_W'(RAM_WAIT);
          end else begin
            state_next = ST_ACK;
            enter_ack  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg <= WAIT_W'(1)) begin
          state_next = ST_ACK;
          enter_ack  = 1'b1;
        end else begin
          cnt_next = cnt_reg - WAIT_W'(1);
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign ram_we = enter_ack && (cur_tgt == TGT_RAM) && (cur_cmd == MWRITE);
  assign ram_re = enter_ack && (cur_tgt == TGT_RAM) && (cur_cmd == MREAD);

  ram_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cur_ram_addr),
    .wdata (cur_data),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      cmd_reg      <= MNONE;
      tgt_reg      <= TGT_ERR;
      ram_addr_reg <= '0;
      data_reg     <= '0;
      rd_reg       <= '0;
      src_ram_reg  <= 1'b0;
      led_reg      <= '0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      halt_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (in_idle) begin
        cmd_reg      <= mem_cmd_t'(mem_cmd);
        tgt_reg      <= cur_tgt;
        ram_addr_reg <= mem_addr[RAM_AW-1:0];
        data_reg     <= write_data;
      end
      if (enter_ack && cur_cmd == MREAD) begin
        src_ram_reg <= (cur_tgt == TGT_RAM);
        case (cur_tgt)
          TGT_LED: rd_reg <= DATA_W'(led_reg);
          TGT_SW:  rd_reg <= DATA_W'(sw_sync_reg);
          default: rd_reg <= '0;
        endcase
      end
      if (enter_ack && cur_cmd == MWRITE && cur_tgt == TGT_LED) begin
        led_reg <= cur_data[7:0];
      end
      sw_meta_reg <= sw_in;
      sw_sync_reg <= sw_meta_reg;
      if (halt_in) begin
        halt_reg <= 1'b1;
      end
    end
  end

  assign read_data = src_ram_reg ? ram_q : rd_reg;
  assign mem_ack   = (state_reg == ST_ACK);
  assign bus_err   = mem_ack && (tgt_reg == TGT_ERR);
  assign led_out   = led_reg;
  assign halt_led  = halt_reg;

endmodule
